// File: rtl/uop_pkg.sv
// Shared types for the micro-op iteration engine.
// Opcodes, FSM state encoding and the program slot record.
package uop_pkg;

    localparam int UOP_IMM_W = 32;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } uop_iter_state_t;

    typedef struct packed {
        op_t                  op;
        logic [UOP_IMM_W-1:0] imm;
        logic                 use_imm;
    } uop_slot_t;

    localparam uop_slot_t SLOT_RESET = '{
        op:      OP_NOP,
        imm:     '0,
        use_imm: 1'b0
    };

endpackage

// File: rtl/microop_unit_dyn.sv
// Combinational micro-op ALU with the opcode as a runtime input.
// Results wrap modulo 2^W; shifts use the shift amount as given.
module microop_unit_dyn
    import uop_pkg::*;
#(
    parameter int W = 32
) (
    input  op_t                    op,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [$clog2(W)-1:0]   shamt,
    output logic [W-1:0]           y
);

    // Select the operation result; NOP passes operand a through.
    always_comb begin
        y = a;
        unique case (op)
            OP_NOP: y = a;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << shamt;
            OP_SHR: y = a >> shamt;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/uop_iter_engine.sv
// Runs a LEN-slot micro-op program over one accumulator per job.
// UOP_ITER_B2B_EN lets DONE accept the next job directly.
module uop_iter_engine
    import uop_pkg::*;
#(
    parameter int LEN = 4,
    parameter int W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [$clog2(LEN)-1:0] prog_addr,
    input  op_t                    prog_op,
    input  logic [W-1:0]           prog_imm,
    input  logic                   prog_use_imm,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [$clog2(W)-1:0]   in_shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   busy
);

    localparam int IW = $clog2(LEN);
    localparam int SW = $clog2(W);

    uop_iter_state_t state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   shamt_q, shamt_d;
    logic            accept;

    uop_slot_t       slots [LEN];
    uop_slot_t       cur;
    logic [W-1:0]    alu_b;
    logic [W-1:0]    alu_y;

    assign cur   = slots[idx_q];
    assign alu_b = cur.use_imm ? W'(cur.imm) : acc_q;

    microop_unit_dyn #(
        .W (W)
    ) u_alu (
        .op    (cur.op),
        .a     (acc_q),
        .b     (alu_b),
        .shamt (shamt_q),
        .y     (alu_y)
    );

    assign busy     = (state_q != IDLE);
    assign out_data = acc_q;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        shamt_d   = shamt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            RUN: begin
                acc_d = alu_y;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(LEN - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef UOP_ITER_B2B_EN
                in_ready = out_ready;
                accept   = out_ready && in_valid;
`endif
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            acc_d   = in_data;
            shamt_d = in_shamt;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    // Control and accumulator registers; reset discards any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            shamt_q <= shamt_d;
        end
    end

    // Program store; writes land only while idle so a job never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                slots[i] <= SLOT_RESET;
            end
        end else if (prog_we && state_q == IDLE
                     && int'(prog_addr) < LEN) begin
            slots[prog_addr] <= '{
                op:      prog_op,
                imm:     UOP_IMM_W'(prog_imm),
                use_imm: prog_use_imm
            };
        end
    end

endmodule
